acl_hdr_parser: RTL and testbench

Header extraction stage directly downstream of the receive FIFO in the ACL datapath. Waits until the FIFO holds a full 10-word (40-byte) header, pops those words with a fixed one-cycle read latency, and decodes the Ethernet/IPv4/L4-port fields. The result goes to the ACL lookup stage over a valid/ready handshake, together with the total frame length in words so the downstream forwarder can drain the payload.

---
 rtl/acl_hdr_parser.sv | 158 +++++++++++++++
 tb/tb_acl_hdr_parser.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acl_hdr_parser.sv
// rtl/acl_hdr_parser.sv - ACL header extraction stage: pops a 10-word header from the RX FIFO and decodes L2/L3/L4 fields
module acl_hdr_parser #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 9,
    parameter int HDR_WORDS  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic [CNT_W-1:0]      i_fifo_cnt,
    output logic                  o_rd_valid,
    output logic                  o_hdr_valid,
    input  logic                  i_hdr_ready,
    output logic [47:0]           o_dst_mac,
    output logic [47:0]           o_src_mac,
    output logic [15:0]           o_ethertype,
    output logic                  o_is_ipv4,
    output logic [7:0]            o_ip_proto,
    output logic [31:0]           o_src_ip,
    output logic [31:0]           o_dst_ip,
    output logic [15:0]           o_src_port,
    output logic [15:0]           o_dst_port,
    output logic                  o_has_ports,
    output logic [14:0]           o_frame_words,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [3:0]       LAST_WORD = 4'(HDR_WORDS - 1);
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(HDR_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  pop_cnt;
    logic [3:0]  cap_cnt;
    logic        rd_d;
    logic [7:0]  ver_ihl;
    logic [15:0] total_len;
    logic [16:0] len_sum;
    logic [16:0] len_round;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pop strobe; the FIFO count is only looked at in IDLE
    always_comb begin
        state_nxt  = state;
        o_rd_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_fifo_cnt >= START_CNT) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                o_rd_valid = 1'b1;
                if (pop_cnt == LAST_WORD) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (i_hdr_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_hdr_valid = (state == S_HOLD);
    assign o_busy      = (state != S_IDLE);

    // Pop and capture counters; capture trails pop by the FIFO's one-cycle read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_cnt <= 4'd0;
            cap_cnt <= 4'd0;
            rd_d    <= 1'b0;
        end else begin
            rd_d <= o_rd_valid;
            if (o_rd_valid) begin
                pop_cnt <= (pop_cnt == LAST_WORD) ? 4'd0 : pop_cnt + 4'd1;
            end
            if (rd_d) begin
                cap_cnt <= (cap_cnt == LAST_WORD) ? 4'd0 : cap_cnt + 4'd1;
            end
        end
    end

    // Field capture: each returned word is scattered into the fields it carries
    always_ff @(posedge clk) begin
        if (rst) begin
            o_dst_mac   <= '0;
            o_src_mac   <= '0;
            o_ethertype <= '0;
            ver_ihl     <= '0;
            total_len   <= '0;
            o_ip_proto  <= '0;
            o_src_ip    <= '0;
            o_dst_ip    <= '0;
            o_src_port  <= '0;
            o_dst_port  <= '0;
        end else if (rd_d) begin
            case (cap_cnt)
                4'd0: o_dst_mac[47:16] <= i_fifo_data;
                4'd1: begin
                    o_dst_mac[15:0]  <= i_fifo_data[31:16];
                    o_src_mac[47:32] <= i_fifo_data[15:0];
                end
                4'd2: o_src_mac[31:0] <= i_fifo_data;
                4'd3: begin
                    o_ethertype <= i_fifo_data[31:16];
                    ver_ihl     <= i_fifo_data[15:8];
                end
                4'd4: total_len <= i_fifo_data[31:16];
                4'd5: o_ip_proto <= i_fifo_data[7:0];
                4'd6: o_src_ip[31:16] <= i_fifo_data[15:0];
                4'd7: begin
                    o_src_ip[15:0]  <= i_fifo_data[31:16];
                    o_dst_ip[31:16] <= i_fifo_data[15:0];
                end
                4'd8: begin
                    o_dst_ip[15:0] <= i_fifo_data[31:16];
                    o_src_port     <= i_fifo_data[15:0];
                end
                4'd9: o_dst_port <= i_fifo_data[31:16];
                default: ;
            endcase
        end
    end

    // Classification and frame length in words (Ethernet header + IPv4 total length, rounded up)
    always_comb begin
        o_is_ipv4     = (o_ethertype == 16'h0800) && (ver_ihl == 8'h45);
        o_has_ports   = o_is_ipv4 && ((o_ip_proto == 8'd6) || (o_ip_proto == 8'd17));
        len_sum       = 17'd14 + {1'b0, total_len};
        len_round     = len_sum + 17'd3;
        o_frame_words = o_is_ipv4 ? len_round[16:2] : 15'd0;
    end

endmodule

// File: tb/tb_acl_hdr_parser.sv
// tb/tb_acl_hdr_parser.sv - directed self-checking bench for acl_hdr_parser
module tb_acl_hdr_parser;

    logic        clk;
    logic        rst;
    logic [31:0] i_fifo_data;
    logic [8:0]  i_fifo_cnt;
    logic        o_rd_valid;
    logic        o_hdr_valid;
    logic        i_hdr_ready;
    logic [47:0] o_dst_mac;
    logic [47:0] o_src_mac;
    logic [15:0] o_ethertype;
    logic        o_is_ipv4;
    logic [7:0]  o_ip_proto;
    logic [31:0] o_src_ip;
    logic [31:0] o_dst_ip;
    logic [15:0] o_src_port;
    logic [15:0] o_dst_port;
    logic        o_has_ports;
    logic [14:0] o_frame_words;
    logic        o_busy;

    int          n_chk;
    int          n_pass;
    int          pops;
    logic [31:0] q[$];
    logic        pend_valid;
    logic [31:0] pend_word;
    logic        manual;

    acl_hdr_parser dut (
        .clk          (clk),
        .rst          (rst),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_cnt   (i_fifo_cnt),
        .o_rd_valid   (o_rd_valid),
        .o_hdr_valid  (o_hdr_valid),
        .i_hdr_ready  (i_hdr_ready),
        .o_dst_mac    (o_dst_mac),
        .o_src_mac    (o_src_mac),
        .o_ethertype  (o_ethertype),
        .o_is_ipv4    (o_is_ipv4),
        .o_ip_proto   (o_ip_proto),
        .o_src_ip     (o_src_ip),
        .o_dst_ip     (o_dst_ip),
        .o_src_port   (o_src_port),
        .o_dst_port   (o_dst_port),
        .o_has_ports  (o_has_ports),
        .o_frame_words(o_frame_words),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle; FIFO model returns popped data one cycle after the pop
    task automatic tick();
        @(negedge clk);
        if (pend_valid) i_fifo_data = pend_word;
        pend_valid = o_rd_valid;
        if (o_rd_valid) begin
            pops++;
            if (q.size() > 0) pend_word = q.pop_front();
        end
        if (!manual) i_fifo_cnt = 9'(q.size());
    endtask

    task automatic push_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                              input logic [7:0] vi, input logic [15:0] tl, input logic [7:0] pr,
                              input logic [31:0] sip, input logic [31:0] dip,
                              input logic [15:0] sp, input logic [15:0] dp);
        q.push_back(dst[47:16]);
        q.push_back({dst[15:0], src[47:32]});
        q.push_back(src[31:0]);
        q.push_back({et, vi, 8'h00});
        q.push_back({tl, 16'h1234});
        q.push_back({16'h4000, 8'h40, pr});
        q.push_back({16'hBEEF, sip[31:16]});
        q.push_back({sip[15:0], dip[31:16]});
        q.push_back({dip[15:0], sp});
        q.push_back({dp, 16'h1111});
    endtask

    task automatic wait_hdr(output int n);
        n = 0;
        while (!o_hdr_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic accept();
        i_hdr_ready = 1'b1;
        tick();
        i_hdr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_hdr_ready = 1'b0;
        i_fifo_data = 32'h0;
        i_fifo_cnt = 9'd0;
        repeat (3) tick();
        n_chk++; if (o_rd_valid !== 1'b0) $display("FAIL reset rd_valid got %b exp 0", o_rd_valid); else n_pass++;
        n_chk++; if (o_hdr_valid !== 1'b0) $display("FAIL reset hdr_valid got %b exp 0", o_hdr_valid); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL reset busy got %b exp 0", o_busy); else n_pass++;
        n_chk++; if (o_dst_mac !== 48'h0) $display("FAIL reset dst_mac got %h exp 0", o_dst_mac); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ipv4_tcp();
        int n;
        pops = 0;
        push_frame(48'h000A35010203, 48'h001122334455, 16'h0800, 8'h45, 16'd46, 8'd6,
                   32'hC0A8010A, 32'h0A000001, 16'd1234, 16'd80);
        i_fifo_cnt = 9'(q.size());
        wait_hdr(n);
        n_chk++; if (n !== 12) $display("FAIL ipv4 latency got %0d exp 12", n); else n_pass++;
        n_chk++; if (pops !== 10) $display("FAIL ipv4 pops got %0d exp 10", pops); else n_pass++;
        n_chk++; if (o_dst_mac !== 48'h000A35010203) $display("FAIL ipv4 dst_mac got %h exp 000a35010203", o_dst_mac); else n_pass++;
        n_chk++; if (o_src_mac !== 48'h001122334455) $display("FAIL ipv4 src_mac got %h exp 001122334455", o_src_mac); else n_pass++;
        n_chk++; if (o_ethertype !== 16'h0800) $display("FAIL ipv4 ethertype got %h exp 0800", o_ethertype); else n_pass++;
        n_chk++; if (o_ip_proto !== 8'd6) $display("FAIL ipv4 proto got %0d exp 6", o_ip_proto); else n_pass++;
        n_chk++; if (o_src_ip !== 32'hC0A8010A) $display("FAIL ipv4 src_ip got %h exp c0a8010a", o_src_ip); else n_pass++;
        n_chk++; if (o_dst_ip !== 32'h0A000001) $display("FAIL ipv4 dst_ip got %h exp 0a000001", o_dst_ip); else n_pass++;
        n_chk++; if (o_src_port !== 16'd1234) $display("FAIL ipv4 src_port got %0d exp 1234", o_src_port); else n_pass++;
        n_chk++; if (o_dst_port !== 16'd80) $display("FAIL ipv4 dst_port got %0d exp 80", o_dst_port); else n_pass++;
        n_chk++; if (o_is_ipv4 !== 1'b1) $display("FAIL ipv4 is_ipv4 got %b exp 1", o_is_ipv4); else n_pass++;
        n_chk++; if (o_has_ports !== 1'b1) $display("FAIL ipv4 has_ports got %b exp 1", o_has_ports); else n_pass++;
        n_chk++; if (o_frame_words !== 15'd15) $display("FAIL ipv4 frame_words got %0d exp 15", o_frame_words); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic bad;
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (!o_hdr_valid || o_rd_valid || o_dst_mac !== 48'h000A35010203 || o_src_ip !== 32'hC0A8010A ||
                o_dst_port !== 16'd80 || o_frame_words !== 15'd15) bad = 1'b1;
        end
        n_chk++; if (bad !== 1'b0) $display("FAIL backpressure hold_stable got %b exp 0", bad); else n_pass++;
        n_chk++; if (pops !== 10) $display("FAIL backpressure pops got %0d exp 10", pops); else n_pass++;
        accept();
        n_chk++; if (o_hdr_valid !== 1'b0) $display("FAIL backpressure hdr_valid_after got %b exp 0", o_hdr_valid); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL backpressure busy_after got %b exp 0", o_busy); else n_pass++;
    endtask

    task automatic test_non_ip();
        int n;
        push_frame(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h0806, 8'h00, 16'h0001, 8'h08,
                   32'h0800_0604, 32'h0001_0011, 16'h2233, 16'h4455);
        wait_hdr(n);
        n_chk++; if (o_hdr_valid !== 1'b1) $display("FAIL arp hdr_valid got %b exp 1", o_hdr_valid); else n_pass++;
        n_chk++; if (o_ethertype !== 16'h0806) $display("FAIL arp ethertype got %h exp 0806", o_ethertype); else n_pass++;
        n_chk++; if (o_is_ipv4 !== 1'b0) $display("FAIL arp is_ipv4 got %b exp 0", o_is_ipv4); else n_pass++;
        n_chk++; if (o_has_ports !== 1'b0) $display("FAIL arp has_ports got %b exp 0", o_has_ports); else n_pass++;
        n_chk++; if (o_frame_words !== 15'd0) $display("FAIL arp frame_words got %0d exp 0", o_frame_words); else n_pass++;
        accept();
        push_frame(48'h000A35010203, 48'h001122334455, 16'h0800, 8'h46, 16'd45, 8'd6,
                   32'hC0A80101, 32'h0A000002, 16'd1000, 16'd22);
        wait_hdr(n);
        n_chk++; if (o_hdr_valid !== 1'b1) $display("FAIL ihl6 hdr_valid got %b exp 1", o_hdr_valid); else n_pass++;
        n_chk++; if (o_is_ipv4 !== 1'b0) $display("FAIL ihl6 is_ipv4 got %b exp 0", o_is_ipv4); else n_pass++;
        n_chk++; if (o_has_ports !== 1'b0) $display("FAIL ihl6 has_ports got %b exp 0", o_has_ports); else n_pass++;
        n_chk++; if (o_frame_words !== 15'd0) $display("FAIL ihl6 frame_words got %0d exp 0", o_frame_words); else n_pass++;
        n_chk++; if (o_dst_port !== 16'd22) $display("FAIL ihl6 raw dst_port got %0d exp 22", o_dst_port); else n_pass++;
        accept();
    endtask

    task automatic test_threshold();
        int n;
        logic seen;
        manual = 1'b1;
        i_fifo_cnt = 9'd9;
        push_frame(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h0800, 8'h45, 16'd20, 8'd6,
                   32'h01020304, 32'h05060708, 16'd7, 16'd8);
        seen = 1'b0;
        repeat (50) begin
            tick();
            if (o_rd_valid) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL threshold cnt9_pop got %b exp 0", seen); else n_pass++;
        i_fifo_cnt = 9'd10;
        tick();
        n_chk++; if (o_rd_valid !== 1'b1) $display("FAIL threshold cnt10_pop got %b exp 1", o_rd_valid); else n_pass++;
        manual = 1'b0;
        wait_hdr(n);
        n_chk++; if (o_frame_words !== 15'd9) $display("FAIL threshold frame_words got %0d exp 9", o_frame_words); else n_pass++;
        accept();
    endtask

    task automatic test_back_to_back();
        int n;
        push_frame(48'h000A35010203, 48'h001122334455, 16'h0800, 8'h45, 16'd46, 8'd6,
                   32'hC0A8010A, 32'h0A000001, 16'd1234, 16'd80);
        push_frame(48'h112233445566, 48'h665544332211, 16'h0800, 8'h45, 16'd100, 8'd17,
                   32'h0A0A0A0A, 32'h08080808, 16'd5353, 16'd53);
        i_fifo_cnt = 9'(q.size());
        i_hdr_ready = 1'b1;
        wait_hdr(n);
        n_chk++; if (o_src_port !== 16'd1234) $display("FAIL b2b frame1 src_port got %0d exp 1234", o_src_port); else n_pass++;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_rd_valid && n < 10);
        n_chk++; if (n !== 2) $display("FAIL b2b accept_to_pop got %0d exp 2", n); else n_pass++;
        wait_hdr(n);
        n_chk++; if (o_ip_proto !== 8'd17) $display("FAIL b2b frame2 proto got %0d exp 17", o_ip_proto); else n_pass++;
        n_chk++; if (o_has_ports !== 1'b1) $display("FAIL b2b frame2 has_ports got %b exp 1", o_has_ports); else n_pass++;
        n_chk++; if (o_dst_port !== 16'd53) $display("FAIL b2b frame2 dst_port got %0d exp 53", o_dst_port); else n_pass++;
        n_chk++; if (o_frame_words !== 15'd29) $display("FAIL b2b frame2 frame_words got %0d exp 29", o_frame_words); else n_pass++;
        tick();
        i_hdr_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n;
        pops = 0;
        push_frame(48'hAABBCCDDEEFF, 48'h001122334455, 16'h0800, 8'h45, 16'd46, 8'd6,
                   32'hC0A8010A, 32'h0A000001, 16'd1234, 16'd80);
        i_fifo_cnt = 9'(q.size());
        n = 0;
        while (pops < 5 && n < 40) begin
            tick();
            n++;
        end
        n_chk++; if (pops !== 5) $display("FAIL midrst pops_before got %0d exp 5", pops); else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++; if (o_rd_valid !== 1'b0) $display("FAIL midrst rd_valid got %b exp 0", o_rd_valid); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL midrst busy got %b exp 0", o_busy); else n_pass++;
        n_chk++; if (o_hdr_valid !== 1'b0) $display("FAIL midrst hdr_valid got %b exp 0", o_hdr_valid); else n_pass++;
        n_chk++; if (o_dst_mac !== 48'h0) $display("FAIL midrst dst_mac got %h exp 0", o_dst_mac); else n_pass++;
        n_chk++; if (o_src_mac !== 48'h0) $display("FAIL midrst src_mac got %h exp 0", o_src_mac); else n_pass++;
        q.delete();
        pend_valid = 1'b0;
        i_fifo_cnt = 9'd0;
        tick();
        rst = 1'b0;
        tick();
        push_frame(48'h02000000BEEF, 48'h020000001234, 16'h0800, 8'h45, 16'hFFFF, 8'd17,
                   32'hDEADBEEF, 32'hCAFEF00D, 16'hABCD, 16'h1357);
        i_fifo_cnt = 9'(q.size());
        wait_hdr(n);
        n_chk++; if (n !== 12) $display("FAIL midrst fresh latency got %0d exp 12", n); else n_pass++;
        n_chk++; if (o_dst_mac !== 48'h02000000BEEF) $display("FAIL midrst fresh dst_mac got %h exp 02000000beef", o_dst_mac); else n_pass++;
        n_chk++; if (o_src_ip !== 32'hDEADBEEF) $display("FAIL midrst fresh src_ip got %h exp deadbeef", o_src_ip); else n_pass++;
        n_chk++; if (o_dst_ip !== 32'hCAFEF00D) $display("FAIL midrst fresh dst_ip got %h exp cafef00d", o_dst_ip); else n_pass++;
        n_chk++; if (o_src_port !== 16'hABCD) $display("FAIL midrst fresh src_port got %h exp abcd", o_src_port); else n_pass++;
        n_chk++; if (o_has_ports !== 1'b1) $display("FAIL midrst fresh has_ports got %b exp 1", o_has_ports); else n_pass++;
        n_chk++; if (o_frame_words !== 15'd16388) $display("FAIL midrst fresh frame_words got %0d exp 16388", o_frame_words); else n_pass++;
        accept();
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        pops = 0;
        pend_valid = 1'b0;
        pend_word = 32'h0;
        manual = 1'b0;
        rst = 1'b1;
        i_hdr_ready = 1'b0;
        i_fifo_data = 32'h0;
        i_fifo_cnt = 9'd0;
        test_reset();
        test_ipv4_tcp();
        test_backpressure();
        test_non_ip();
        test_threshold();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
